// File: rtl/operand_frame_loader.sv
// operand_frame_loader
//   Serial-to-parallel front end for the function-evaluation stage. A framed
//   serial stream (MSB first, operands a,b,c,d,e in that order) is assembled in
//   a shift register. A completed frame is handed to a registered valid/ready
//   output stage. The shift register keeps accepting bits while the output
//   stage holds the previous frame, which gives one frame of buffering.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   ser_in     serial data bit
//   ser_valid  ser_in valid this cycle
//   ser_start  with ser_valid: this bit is the first bit of a frame
//   a..e       assembled operands, held stable while out_valid=1
//   out_valid  operand set available
//   out_ready  downstream accepts (transfer on out_valid & out_ready)
//   frame_err  1-cycle pulse: frame aborted by an early ser_start
//   overflow   1-cycle pulse: completed frame dropped, output still occupied
//
// state | meaning
// IDLE  | waiting for a start bit; bits without ser_start are ignored
// SHIFT | inside a frame; bit_cnt holds the number of bits accepted so far

module operand_frame_loader #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ser_in,
   input  logic             ser_valid,
   input  logic             ser_start,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] c,
   output logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] e,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             frame_err,
   output logic             overflow
);

   localparam int FLEN = 5 * WIDTH;
   localparam int CW   = $clog2(FLEN + 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t          state;
   logic [CW-1:0]   bit_cnt;
   logic [FLEN-1:0] shift_reg;

   logic            accept;
   logic            complete;
   logic            transfer;
   logic [CW-1:0]   cnt_next;
   logic [FLEN-1:0] sr_next;

   always_comb begin
      // A start bit always begins a new frame, aborted or not.
      accept   = ser_valid && (ser_start || (state == SHIFT));
      cnt_next = ser_start ? CW'(1) : bit_cnt + CW'(1);
      sr_next  = {shift_reg[FLEN-2:0], ser_in};
      complete = accept && (cnt_next == CW'(FLEN));
      transfer = out_valid && out_ready;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         shift_reg <= '0;
         a         <= '0;
         b         <= '0;
         c         <= '0;
         d         <= '0;
         e         <= '0;
         out_valid <= 1'b0;
         frame_err <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         frame_err <= ser_valid && ser_start && (state == SHIFT);
         overflow  <= 1'b0;

         if (accept) begin
            shift_reg <= sr_next;
            if (complete) begin
               bit_cnt <= '0;
               state   <= IDLE;
            end else begin
               bit_cnt <= cnt_next;
               state   <= SHIFT;
            end
         end

         // A transfer in the completion cycle frees the slot for the new frame,
         // so out_valid stays high without a bubble.
         if (complete) begin
            if (!out_valid || out_ready) begin
               {a, b, c, d, e} <= sr_next;
               out_valid       <= 1'b1;
            end else begin
               overflow <= 1'b1;
            end
         end else if (transfer) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
